// File: rtl/i2s_sample_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2s_sample_fifo                                                 |
// | Purpose  : Stereo sample FIFO between the mixer path and the I2S           |
// |            transmitter. Pairs are pushed over a valid/ready handshake and  |
// |            one pair is popped onto held output registers on every rising   |
// |            edge of the (asynchronous) transmitter frame clock. An empty    |
// |            FIFO at pop time holds the last pair and flags an underrun.     |
// | Ports    : clk, reset        - system clock, async active-high reset       |
// |            in_left/in_right  - sample pair offered by the producer         |
// |            in_valid/in_ready - push handshake (ready = level != DEPTH)     |
// |            frame_clk         - transmitter frame clock (async input)       |
// |            sample_left/right - held pair presented to the transmitter      |
// |            level             - FIFO occupancy 0..DEPTH                     |
// |            underrun          - one-cycle pulse on a pop from empty         |
// |            underrun_count    - saturating underrun counter                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module i2s_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_left,
  input  logic [WIDTH-1:0]         in_right,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     frame_clk,
  output logic [WIDTH-1:0]         sample_left,
  output logic [WIDTH-1:0]         sample_right,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun,
  output logic [7:0]               underrun_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [2*WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] left_q, left_d;
  logic [WIDTH-1:0] right_q, right_d;
  logic             underrun_q, underrun_d;
  logic [7:0]       ucnt_q, ucnt_d;

  logic push;
  logic pop_evt;
  logic do_pop;
  logic do_under;

  // Ready depends on occupancy only, so there is no in_valid -> in_ready path.
  assign in_ready = (level_q != FULL_LEVEL);
  assign push     = in_valid & in_ready;

  // s1/s2 resynchronise frame_clk; s3 is the delayed copy for edge detection.
  assign pop_evt  = s2_q & ~s3_q;
  assign do_pop   = pop_evt & (level_q != '0);
  assign do_under = pop_evt & (level_q == '0);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    left_d     = left_q;
    right_d    = right_q;
    underrun_d = do_under;
    ucnt_d     = ucnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    // A pair written this cycle is never visible to a pop decided this cycle:
    // the read only happens when the FIFO already held data before the edge.
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      left_d   = mem_q[rd_ptr_q][2*WIDTH-1:WIDTH];
      right_d  = mem_q[rd_ptr_q][WIDTH-1:0];
    end

    if (do_under && (ucnt_q != 8'hFF)) begin
      ucnt_d = ucnt_q + 8'd1;
    end

    // An underrun does not consume an entry, so push+underrun counts as push.
    case ({push, do_pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      left_q     <= '0;
      right_q    <= '0;
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      s1_q       <= frame_clk;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      left_q     <= left_d;
      right_q    <= right_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once the
  // pointers and level are cleared.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= {in_left, in_right};
    end
  end

  assign sample_left    = left_q;
  assign sample_right   = right_q;
  assign level          = level_q;
  assign underrun       = underrun_q;
  assign underrun_count = ucnt_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_sample_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_i2s_sample_fifo                                              |
// | Purpose  : Self-checking bench for i2s_sample_fifo. A queue-based model    |
// |            tracks the expected FIFO contents and outputs; a per-cycle      |
// |            compare checks the DUT against it, and directed scenarios add   |
// |            hand-computed literal expectations.                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_i2s_sample_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_left, in_right;
  logic             in_valid;
  logic             in_ready;
  logic             frame_clk;
  logic [WIDTH-1:0] sample_left, sample_right;
  logic [3:0]       level;
  logic             underrun;
  logic [7:0]       underrun_count;

  i2s_sample_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_left        (in_left),
    .in_right       (in_right),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .frame_clk      (frame_clk),
    .sample_left    (sample_left),
    .sample_right   (sample_right),
    .level          (level),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] mq[$];
  logic [15:0] m_left  = '0;
  logic [15:0] m_right = '0;
  logic        m_under = 1'b0;
  int          m_cnt   = 0;
  int          rise_age = 0;   // clk edges seen since a frame_clk rise
  bit          rise_seen = 1'b0;
  bit          do_pop;
  bit          push_ok;
  logic [31:0] popped;
  bit          started = 1'b0;

  always @(posedge frame_clk) rise_seen = 1'b1;

  // The pair leaves the FIFO on the third clk edge after a frame_clk rise.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_left = '0; m_right = '0; m_under = 1'b0; m_cnt = 0;
      rise_age = 0; rise_seen = 1'b0;
    end else begin
      do_pop  = 1'b0;
      m_under = 1'b0;
      if (rise_age != 0) rise_age++;
      if (rise_seen) begin rise_age = 1; rise_seen = 1'b0; end
      if (rise_age == 3) begin do_pop = 1'b1; rise_age = 0; end
      push_ok = in_valid && (mq.size() != DEPTH);
      if (do_pop) begin
        if (mq.size() > 0) begin
          popped  = mq.pop_front();
          m_left  = popped[31:16];
          m_right = popped[15:0];
        end else begin
          m_under = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end
      if (push_ok) mq.push_back({in_left, in_right});
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("level",          32'(level),          32'(mq.size()));
      chk("in_ready",       32'(in_ready),       32'(mq.size() != DEPTH));
      chk("sample_left",    32'(sample_left),    32'(m_left));
      chk("sample_right",   32'(sample_right),   32'(m_right));
      chk("underrun",       32'(underrun),       32'(m_under));
      chk("underrun_count", 32'(underrun_count), 32'(m_cnt));
    end
  end

  // ---------------- stimulus helpers ----------------
  int und_cycles;
  int chg_edge;

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    bit ok;
    bit done = 1'b0;
    in_left = l; in_right = r; in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      ok = in_ready;
      @(posedge clk); #2;
      if (ok) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 32'd1, 32'd0);
  endtask

  // One 64-cycle frame; optionally lands a push on the pop edge.
  task automatic frame(input bit push_at_pop, input logic [15:0] l, input logic [15:0] r);
    logic [15:0] pre;
    und_cycles = 0;
    chg_edge   = -1;
    @(posedge clk); #2;
    pre = sample_left;
    frame_clk = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #2;
      if (push_at_pop && i == 1) begin
        in_left = l; in_right = r; in_valid = 1'b1;
      end
      if (push_at_pop && i == 2) in_valid = 1'b0;
      if (underrun) und_cycles++;
      if (sample_left !== pre && chg_edge < 0) chg_edge = i;
      if (i == 31) frame_clk = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_left = '0; in_right = '0; frame_clk = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    started = 1'b1;

    // Reset defaults, including a reset mid-stream at level 5.
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 5; k++) push(16'(k + 16'h0050), 16'(k + 16'h0060));
    chk("pre_rst_level", 32'(level), 32'd5);
    reset = 1'b1;
    @(posedge clk); #2;
    chk("in_rst_level", 32'(level), 32'd0);
    @(posedge clk); #2 reset = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("post_rst_level", 32'(level), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    chk("post_rst_left",  32'(sample_left), 32'd0);
    chk("post_rst_right", 32'(sample_right), 32'd0);
    chk("post_rst_ucnt",  32'(underrun_count), 32'd0);

    // Ordered pops, 3 cycles after each rise.
    push(16'h1111, 16'hAAAA);
    push(16'h2222, 16'hBBBB);
    push(16'h3333, 16'hCCCC);
    chk("ord_level0", 32'(level), 32'd3);
    frame(1'b0, '0, '0);
    chk("ord_edge1",  32'(chg_edge), 32'd2);
    chk("ord_left1",  32'(sample_left), 32'h1111);
    chk("ord_right1", 32'(sample_right), 32'hAAAA);
    chk("ord_level1", 32'(level), 32'd2);
    frame(1'b0, '0, '0);
    chk("ord_edge2",  32'(chg_edge), 32'd2);
    chk("ord_left2",  32'(sample_left), 32'h2222);
    chk("ord_level2", 32'(level), 32'd1);
    frame(1'b0, '0, '0);
    chk("ord_edge3",  32'(chg_edge), 32'd2);
    chk("ord_right3", 32'(sample_right), 32'hCCCC);
    chk("ord_level3", 32'(level), 32'd0);

    // Underrun holds outputs, pulses once, and saturates the counter.
    push(16'h1234, 16'h5678);
    frame(1'b0, '0, '0);
    frame(1'b0, '0, '0);
    chk("und_pulse", 32'(und_cycles), 32'd1);
    chk("und_left",  32'(sample_left), 32'h1234);
    chk("und_right", 32'(sample_right), 32'h5678);
    chk("und_cnt1",  32'(underrun_count), 32'd1);
    for (int k = 0; k < 300; k++) frame(1'b0, '0, '0);
    chk("und_cnt_sat", 32'(underrun_count), 32'd255);

    // Push coinciding with an underrun at level 0.
    frame(1'b1, 16'hABCD, 16'hDCBA);
    chk("sim0_pulse", 32'(und_cycles), 32'd1);
    chk("sim0_level", 32'(level), 32'd1);
    chk("sim0_left",  32'(sample_left), 32'h1234);
    frame(1'b0, '0, '0);
    chk("sim0_pop",   32'(sample_left), 32'hABCD);

    // Full and backpressure.
    for (int k = 1; k <= 8; k++) push(16'(16'h0100 + k), 16'(16'hF000 + k));
    chk("full_level", 32'(level), 32'd8);
    chk("full_ready", 32'(in_ready), 32'd0);
    in_left = 16'h0109; in_right = 16'hF009; in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("bp_level", 32'(level), 32'd8);
    fork
      frame(1'b0, '0, '0);
      push(16'h0109, 16'hF009);
    join
    chk("bp_left",   32'(sample_left), 32'h0101);
    chk("bp_level2", 32'(level), 32'd8);

    // Push coinciding with a pop at level 4.
    for (int k = 0; k < 4; k++) frame(1'b0, '0, '0);
    chk("sim4_pre", 32'(level), 32'd4);
    frame(1'b1, 16'h010A, 16'hF00A);
    chk("sim4_left",  32'(sample_left), 32'h0106);
    chk("sim4_right", 32'(sample_right), 32'hF006);
    chk("sim4_level", 32'(level), 32'd4);
    for (int k = 0; k < 4; k++) frame(1'b0, '0, '0);
    chk("drain_left",  32'(sample_left), 32'h010A);
    chk("drain_level", 32'(level), 32'd0);

    // Pointer wrap over 20 push/pop pairs.
    for (int k = 0; k < 20; k++) begin
      push(16'(16'h2000 + k), 16'(16'h3000 + k));
      frame(1'b0, '0, '0);
    end
    chk("wrap_left",  32'(sample_left), 32'h2013);
    chk("wrap_right", 32'(sample_right), 32'h3013);
    chk("wrap_level", 32'(level), 32'd0);

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
